// File: rtl/mult_controller.sv
// Control FSM for the 8-bit shift-add multiplier datapath: sequences operand loads,
// N_BITS add/shift steps and result readout. Optional abort input via MULT_CTRL_ABORT_EN.
module mult_controller #(
  parameter int unsigned N_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic A0,
`ifdef MULT_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic clr_P,
  output logic load_P,
  output logic load_B,
  output logic load_A,
  output logic shift_A,
  output logic sel_sum,
  output logic lsb_out,
  output logic msb_out,
  output logic req_a,
  output logic req_b,
  output logic res_lo_valid,
  output logic res_hi_valid,
  output logic busy,
  output logic done
);

  localparam int unsigned CW = $clog2(N_BITS);

  typedef enum logic [2:0] {
    IDLE, LD_A, LD_B, MULT, OUT_LO, OUT_HI, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            abort_c;

  logic clr_p_d, load_p_d, load_b_d, load_a_d, shift_a_d;
  logic lsb_out_d, msb_out_d, req_a_d, req_b_d;
  logic res_lo_valid_d, res_hi_valid_d, busy_d, done_d;

`ifdef MULT_CTRL_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Next state and iteration counter
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LD_A;
      LD_A:    state_d = LD_B;
      LD_B: begin
        state_d = MULT;
        count_d = '0;
      end
      MULT: begin
        if (count_q == CW'(N_BITS - 1)) state_d = OUT_LO;
        else                            count_d = count_q + CW'(1);
      end
      OUT_LO:  state_d = OUT_HI;
      OUT_HI:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_c && (state_q != IDLE)) begin
      state_d = IDLE;
      count_d = '0;
    end
  end

  // Outputs decoded from the next state so the registered copies track state_q
  always_comb begin
    clr_p_d        = 1'b0;
    load_p_d       = 1'b0;
    load_b_d       = 1'b0;
    load_a_d       = 1'b0;
    shift_a_d      = 1'b0;
    lsb_out_d      = 1'b0;
    msb_out_d      = 1'b0;
    req_a_d        = 1'b0;
    req_b_d        = 1'b0;
    res_lo_valid_d = 1'b0;
    res_hi_valid_d = 1'b0;
    done_d         = 1'b0;
    busy_d         = (state_d != IDLE);
    unique case (state_d)
      LD_A: begin
        load_a_d = 1'b1;
        req_a_d  = 1'b1;
      end
      LD_B: begin
        load_b_d = 1'b1;
        clr_p_d  = 1'b1;
        load_p_d = 1'b1;
        req_b_d  = 1'b1;
      end
      MULT: begin
        load_p_d  = 1'b1;
        shift_a_d = 1'b1;
      end
      OUT_LO: begin
        lsb_out_d      = 1'b1;
        res_lo_valid_d = 1'b1;
      end
      OUT_HI: begin
        msb_out_d      = 1'b1;
        res_hi_valid_d = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      clr_P        <= 1'b0;
      load_P       <= 1'b0;
      load_B       <= 1'b0;
      load_A       <= 1'b0;
      shift_A      <= 1'b0;
      lsb_out      <= 1'b0;
      msb_out      <= 1'b0;
      req_a        <= 1'b0;
      req_b        <= 1'b0;
      res_lo_valid <= 1'b0;
      res_hi_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      clr_P        <= clr_p_d;
      load_P       <= load_p_d;
      load_B       <= load_b_d;
      load_A       <= load_a_d;
      shift_A      <= shift_a_d;
      lsb_out      <= lsb_out_d;
      msb_out      <= msb_out_d;
      req_a        <= req_a_d;
      req_b        <= req_b_d;
      res_lo_valid <= res_lo_valid_d;
      res_hi_valid <= res_hi_valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

  // Only Mealy output: add B when the current multiplier bit is set
  assign sel_sum = (state_q == MULT) && A0;

endmodule

// File: tb/tb_mult_controller.sv
// Bench for mult_controller: behavioural shift-add datapath + host, table-driven
// operations with a result-byte scoreboard, plus reset/abort corner sequences.
module tb_mult_controller;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic A0;
  logic abort;
  logic clr_P, load_P, load_B, load_A, shift_A, sel_sum, lsb_out, msb_out;
  logic req_a, req_b, res_lo_valid, res_hi_valid, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_controller #(.N_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A0(A0),
`ifdef MULT_CTRL_ABORT_EN
    .abort(abort),
`endif
    .clr_P(clr_P), .load_P(load_P), .load_B(load_B), .load_A(load_A),
    .shift_A(shift_A), .sel_sum(sel_sum), .lsb_out(lsb_out), .msb_out(msb_out),
    .req_a(req_a), .req_b(req_b), .res_lo_valid(res_lo_valid),
    .res_hi_valid(res_hi_valid), .busy(busy), .done(done)
  );

  // Host operands and a shift-add datapath driven by the controller strobes
  logic [7:0] op_a, op_b, a_reg, b_reg, p_reg, bus;
  logic [8:0] sum;

  assign bus = req_a ? op_a : req_b ? op_b : lsb_out ? a_reg : msb_out ? p_reg : 8'h00;
  assign sum = {1'b0, p_reg} + (sel_sum ? {1'b0, b_reg} : 9'd0);
  assign A0  = a_reg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= 8'h00;
      b_reg <= 8'h00;
      p_reg <= 8'h00;
    end else begin
      if (load_A)       a_reg <= bus;
      else if (shift_A) a_reg <= {sum[0], a_reg[7:1]};
      if (load_B)       b_reg <= bus;
      if (load_P)       p_reg <= clr_P ? 8'h00 : sum[8:1];
    end
  end

  localparam int B_CLRP = 13, B_LDP = 12, B_LDB = 11, B_LDA = 10, B_SHA = 9, B_SEL = 8;
  localparam int B_LSB = 7, B_MSB = 6, B_RQA = 5, B_RQB = 4, B_RLO = 3, B_RHI = 2;
  localparam int B_BUSY = 1, B_DONE = 0;

  logic [7:0] exp_q[$];

  function automatic logic [13:0] outs();
    return {clr_P, load_P, load_B, load_A, shift_A, sel_sum, lsb_out, msb_out,
            req_a, req_b, res_lo_valid, res_hi_valid, busy, done};
  endfunction

  // Expected strobes for cycle k after start was sampled (N_BITS=8)
  function automatic logic [13:0] exp_vec(int k, logic [7:0] a);
    logic [13:0] v = '0;
    if (k >= 1 && k <= 13) v[B_BUSY] = 1'b1;
    if (k == 1) begin v[B_LDA] = 1'b1; v[B_RQA] = 1'b1; end
    if (k == 2) begin v[B_LDB] = 1'b1; v[B_CLRP] = 1'b1; v[B_LDP] = 1'b1; v[B_RQB] = 1'b1; end
    if (k >= 3 && k <= 10) begin
      v[B_LDP] = 1'b1; v[B_SHA] = 1'b1; v[B_SEL] = a[k-3];
    end
    if (k == 11) begin v[B_LSB] = 1'b1; v[B_RLO] = 1'b1; end
    if (k == 12) begin v[B_MSB] = 1'b1; v[B_RHI] = 1'b1; end
    if (k == 13) v[B_DONE] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe check plus scoreboard pop whenever a result byte is flagged
  task automatic check_cycle(input string name, input logic [13:0] exp);
    logic [7:0] e;
    check(name, 32'(outs()), 32'(exp));
    if (res_lo_valid || res_hi_valid) begin
      if (exp_q.size() == 0) begin
        check({name, "_unexpected_result"}, 32'(bus), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check({name, "_bus"}, 32'(bus), 32'(e));
      end
    end
  endtask

  // mode 0: start pulse; 1: start held; 2: start poked in MULT and DONE
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] lo, input logic [7:0] hi, input int mode);
    op_a = a;
    op_b = b;
    start = 1'b1;
    exp_q.push_back(lo);
    exp_q.push_back(hi);
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); @(negedge clk);
      start = (mode == 1) || (mode == 2 && (k == 5 || k == 13));
      check_cycle($sformatf("op%02h_c%0d", a, k), exp_vec(k, a));
    end
    @(posedge clk); @(negedge clk);
    if (mode != 1) start = 1'b0;
    check_cycle($sformatf("op%02h_idle", a), 14'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    int         mode;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h03, 8'h05, 8'h0F, 8'h00, 0};
    vecs[1] = '{8'hFF, 8'hFF, 8'h01, 8'hFE, 0};
    vecs[2] = '{8'hA5, 8'h01, 8'hA5, 8'h00, 2};
    vecs[3] = '{8'h00, 8'h7F, 8'h00, 8'h00, 1};
    vecs[4] = '{8'h80, 8'h80, 8'h00, 8'h40, 1};
    vecs[5] = '{8'hC3, 8'h3C, 8'hB4, 8'h2D, 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; op_a = 8'h00; op_b = 8'h00;
    @(negedge clk);
    check("reset_hold", 32'(outs()), 32'd0);
    start = 1'b1;
    @(negedge clk);
    check("reset_start_ignored", 32'(outs()), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(outs()), 32'd0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].mode);
    check("idle_no_restart", 32'(outs()), 32'd0);

    // Reset asserted during the fifth MULT cycle aborts asynchronously
    op_a = 8'h12; op_b = 8'h34; start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_mult", 32'(outs()), 32'(exp_vec(7, 8'h12)));
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    check("rst_held", 32'(outs()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_abort_rst", 32'(outs()), 32'd0);
    run_op(8'h07, 8'h09, 8'h3F, 8'h00, 0);

`ifdef MULT_CTRL_ABORT_EN
    // Abort in cycle 6: back to IDLE at cycle 7, no results and no done
    op_a = 8'h55; op_b = 8'h22; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check_cycle($sformatf("abort_c%0d", k), exp_vec(k, 8'h55));
    end
    abort = 1'b1;
    #1 check("abort_cycle_outputs", 32'(outs()), 32'(exp_vec(6, 8'h55)));
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    for (int k = 7; k <= 15; k++) begin
      check_cycle($sformatf("aborted_c%0d", k), 14'd0);
      @(posedge clk); @(negedge clk);
    end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_in_idle", 32'(outs()), 32'd0);
    abort = 1'b0;
    run_op(8'h0B, 8'h0D, 8'h8F, 8'h00, 0);
`endif

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
